load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit sitting directly upstream of the 32-word data memory, between the pipeline's MEM stage and the memory's word-only port. It accepts one RV32I load or store request at a time and drives word-indexed read/write enables. It performs alignment checks, byte-lane extraction with sign/zero extension for LB/LH/LW/LBU/LHU, and read-modify-write sequencing for SB/SH. A ready/valid handshake stalls the pipeline while a request is in flight.

## Interface
- `ADDR_W`, 32: request byte-address width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 of the load/store.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid` out 1: one-cycle pulse, request complete.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned address or illegal funct3; valid with `resp_valid`.
- `mem_addr` out 32: word index {2'b0, addr[31:2]}.
- `mem_rd_en` out 1: memory read enable.
- `mem_wr_en` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: combinational memory read data, valid the same cycle as `mem_rd_en`.

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. On accept, addr, we, funct3 and wdata are latched.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is an error.
- Misaligned: for H, addr[0]≠0. For W, addr[1:0]≠0.
- States:
  - IDLE: all mem_* outputs are 0.
    - Accept with error → ERR.
    - Accept load → LD.
    - Accept SW → WR.
    - Accept SB/SH → RD.
  - LD: `mem_rd_en`=1. Extract the lane from `mem_rdata` using addr[1:0], little-endian, then sign- or zero-extend into `resp_rdata`. → IDLE, with `resp_valid` pulsed.
  - RD: `mem_rd_en`=1. Merge the store byte/halfword into `mem_rdata` at the addressed lane and register the merged word. → WR.
  - WR: `mem_wr_en`=rst_n. `mem_wdata` is the merged word, or req_wdata for SW. → IDLE, with `resp_valid` pulsed.
  - ERR: no memory access. → IDLE, with `resp_valid`=1 and `resp_err`=1.
- `mem_rd_en` and `mem_wr_en` are never high together.
- `mem_addr` holds the latched word index in every non-IDLE state.
- Upper address bits beyond what the memory decodes are passed through unchecked.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, internal merge register=0.
- Accept at cycle N:
  - Error: `resp_valid` in cycle N+1.
  - Load and SW: `resp_valid` in cycle N+2.
  - SB/SH: `resp_valid` in cycle N+3.
- Memory write commits at the end of the WR cycle. The same cycle as `resp_valid`, the unit is in IDLE with `req_ready`=1, so back-to-back accept is allowed.
- Throughput: one request per 2 cycles (load/SW) or 3 cycles (SB/SH).
- The response outputs are registered and valid only while `resp_valid`=1. They hold their value otherwise; the bench must not check them.
- Reset mid-operation: returns to IDLE next edge and drops the in-flight request with no `resp_valid`. Because `mem_wr_en` is gated by `rst_n`, a reset in the WR cycle suppresses the write.
- `req_*` inputs are ignored when `req_ready`=0.

## Structure
- `lsu_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: IDLE, LD, RD, WR, ERR.
  - Function `lsu_misaligned(funct3, addr[1:0])`.
- Sub-module `lsu_lane`: purely combinational.
  - Extract: rdata, addr[1:0], funct3 → extended load value.
  - Merge: old word, wdata, addr[1:0], funct3 → merged word.
  - Instantiated once; the FSM stays in `load_store_unit`.

## Test plan
- SW: addr 0x14, data 0xDEADBEEF, accept at N.
  - Cycle N+1: `mem_wr_en`=1, `mem_addr`=5.
  - Word 5 = 0xDEADBEEF; `resp_valid` at N+2, `resp_err`=0.
- Sign/zero extension on word 5 = 0xDEADBEEF:
  - LB 0x17 → 0xFFFFFFDE at N+2.
  - LBU 0x17 → 0x000000DE.
  - LH 0x14 → 0xFFFFBEEF.
  - LHU 0x16 → 0x0000DEAD.
- SH: addr 0x16, data 0x1234CAFE.
  - RD at N+1, WR at N+2; word 5 = 0xCAFEBEEF; `resp_valid` at N+3.
  - Follow with SB 0x14, data 0x77 → word 5 = 0xCAFEBE77.
- Errors, each giving `resp_err`=1 at N+1 with no mem enable asserted in any cycle:
  - LH 0x15.
  - SW 0x16.
  - Load funct3=011.
- Back-to-back: SW 0x08 = 0xA5A5A5A5, then LW 0x08 accepted in the SW's `resp_valid` cycle → LW returns 0xA5A5A5A5.
- Reset: `rst_n`=0 during the WR cycle of SB 0x14.
  - Word 5 unchanged.
  - No `resp_valid`.
  - Next cycle: `req_ready`=1 and all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and request-legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    RD,
    WR,
    ERR
  } state_t;

  function automatic logic lsu_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic bad;
    bad = 1'b0;
    if (funct3 == F3_H || funct3 == F3_HU)
      bad = addr[0];
    else if (funct3 == F3_W)
      bad = |addr;
    return bad;
  endfunction

  function automatic logic lsu_illegal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic bad;
    if (we)
      bad = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      bad = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte-lane datapath: load extraction with sign/zero extension and
// sub-word store merge. Ports: funct3, lane, rdata, wdata -> ld_data, merged.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    ld_data = '0;
    unique case (funct3)
      F3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU: ld_data = {24'h0, shifted[7:0]};
      F3_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU: ld_data = {16'h0, shifted[15:0]};
      F3_W:  ld_data = shifted;
      default: ld_data = '0;
    endcase
  end

  // Store merge: lane 0..3 for bytes, lane[1] picks the halfword.
  always_comb begin
    merged = rdata;
    unique case (funct3)
      F3_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU in front of a word-only memory port.
// Ports: req_* (valid/ready request), resp_* (result pulse), mem_* (word port).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       ld_data;
  logic [31:0]       merged;
  logic              req_bad;

  lsu_lane u_lane (
    .funct3  (funct3_q),
    .lane    (addr_q[1:0]),
    .rdata   (mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .merged  (merged)
  );

  assign req_ready = (state == IDLE);
  assign req_bad   = lsu_illegal(req_we, req_funct3)
                   | lsu_misaligned(req_funct3, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            // Errors respond straight from the accept edge.
            if (req_bad) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state <= LD;
            end else if (req_funct3 == F3_W) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        LD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
          state      <= IDLE;
        end
        RD: begin
          merge_q <= merged;
          state   <= WR;
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = (state == LD) || (state == RD);
  // Gating by rst_n lets a reset during WR cancel the write.
  assign mem_wr_en = (state == WR) && rst_n;
  assign mem_addr  = (state == IDLE) ? '0
                   : {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_wdata = (state != WR) ? '0
                   : (funct3_q == F3_W) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word memory model
// and an expected-response queue.
module tb_load_store_unit;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32];
  logic        clr;
  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          overlap = 0;

  logic        c_rd [1:6];
  logic        c_wr [1:6];
  logic [31:0] c_addr1;
  logic        any_en;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_wr_en) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_rd_en ? mem[mem_addr[4:0]] : 32'h0;

  always @(negedge clk)
    if (mem_rd_en && mem_wr_en) overlap++;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] erd);
    for (int i = 0; i < 4 && !req_ready; i++) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    q.push_back('{err: eerr, rdata: erd});
    @(posedge clk);
  endtask

  task automatic wait_resp(input string name, input int lat);
    int   got;
    exp_t e;
    got    = 0;
    any_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      c_rd[k] = mem_rd_en;
      c_wr[k] = mem_wr_en;
      if (k == 1) c_addr1 = mem_addr;
      any_en = any_en | mem_rd_en | mem_wr_en;
      if (resp_valid) begin
        got = k;
        break;
      end
    end
    chk({name, "_lat"}, got, lat);
    if (got != 0 && q.size() > 0) begin
      e = q.pop_front();
      chk({name, "_err"}, 32'(resp_err), 32'(e.err));
      chk({name, "_rdata"}, resp_rdata, e.rdata);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_en", 32'({mem_rd_en, mem_wr_en}), 0);
    rst_n = 1'b1;
    clr   = 1'b0;
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 1'b0, 32'h0);
    wait_resp("sw", 2);
    chk("sw_wr_c1", 32'(c_wr[1]), 1);
    chk("sw_addr_c1", c_addr1, 32'd5);
    chk("sw_word5", mem[5], 32'hDEADBEEF);

    issue(1'b0, 3'b000, 32'h17, 32'h0, 1'b0, 32'hFFFFFFDE);
    wait_resp("lb", 2);
    chk("lb_rd_c1", 32'(c_rd[1]), 1);
    issue(1'b0, 3'b100, 32'h17, 32'h0, 1'b0, 32'h000000DE);
    wait_resp("lbu", 2);
    issue(1'b0, 3'b001, 32'h14, 32'h0, 1'b0, 32'hFFFFBEEF);
    wait_resp("lh", 2);
    issue(1'b0, 3'b101, 32'h16, 32'h0, 1'b0, 32'h0000DEAD);
    wait_resp("lhu", 2);

    issue(1'b1, 3'b001, 32'h16, 32'h1234CAFE, 1'b0, 32'h0);
    wait_resp("sh", 3);
    chk("sh_rd_c1", 32'({c_rd[1], c_wr[1]}), 32'b10);
    chk("sh_wr_c2", 32'({c_rd[2], c_wr[2]}), 32'b01);
    chk("sh_word5", mem[5], 32'hCAFEBEEF);
    issue(1'b1, 3'b000, 32'h14, 32'h00000077, 1'b0, 32'h0);
    wait_resp("sb", 3);
    chk("sb_word5", mem[5], 32'hCAFEBE77);

    issue(1'b0, 3'b001, 32'h15, 32'h0, 1'b1, 32'h0);
    wait_resp("e_lh", 1);
    chk("e_lh_noen", 32'(any_en), 0);
    issue(1'b1, 3'b010, 32'h16, 32'h0, 1'b1, 32'h0);
    wait_resp("e_sw", 1);
    chk("e_sw_noen", 32'(any_en), 0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0);
    wait_resp("e_f3", 1);
    chk("e_f3_noen", 32'(any_en), 0);
    @(negedge clk);
    chk("e_f3_noen2", 32'({mem_rd_en, mem_wr_en}), 0);

    issue(1'b1, 3'b010, 32'h08, 32'hA5A5A5A5, 1'b0, 32'h0);
    wait_resp("b2b_sw", 2);
    chk("b2b_ready", 32'(req_ready), 1);
    issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hA5A5A5A5);
    wait_resp("b2b_lw", 2);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h14;
    req_wdata  = 32'h00000011;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_sb_rd", 32'(mem_rd_en), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sb_nowr", 32'(mem_wr_en), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_sb_valid", 32'(resp_valid), 0);
    chk("rst_sb_ready", 32'(req_ready), 1);
    chk("rst_sb_rdata", resp_rdata, 0);
    chk("rst_sb_err", 32'(resp_err), 0);
    chk("rst_sb_mem", 32'({mem_rd_en, mem_wr_en}), 0);
    chk("rst_sb_addr", mem_addr, 0);
    chk("rst_sb_word5", mem[5], 32'hCAFEBE77);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sb_valid2", 32'(resp_valid), 0);

    issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'hCAFEBE77);
    wait_resp("lw5", 2);

    chk("queue_empty", q.size(), 0);
    chk("rd_wr_excl", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
